// File: rtl/tow_round_ctrl.sv
// Tug-of-war round sequencer: arms the push latch, times a pseudo-random GO
// delay, scores the latched result onto the rope position and declares a winner.
module tow_round_ctrl #(
  parameter int unsigned POS_MAX    = 4,
  parameter int unsigned POS_W      = 4,
  parameter int unsigned MIN_DELAY  = 50,
  parameter int unsigned HOLD_TICKS = 500,
  parameter int unsigned CNT_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             push,
  input  logic             tie,
  input  logic             right,
  output logic             clear,
  output logic             go,
  output logic [POS_W-1:0] pos,
  output logic             false_start,
  output logic             round_done,
  output logic             winner_valid,
  output logic             winner_right
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GO,
    S_SCORE,
    S_HOLD,
    S_WIN
  } state_t;

  localparam logic [POS_W-1:0] POS_MID = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_TOP = POS_W'(2 * POS_MAX);

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             clear_q, clear_d;
  logic             fs_q, fs_d;
  logic             rd_q, rd_d;
  logic             push_m_q, push_s_q;
  logic             tie_m_q, tie_s_q;
  logic             right_m_q, right_s_q;
  logic             step_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pos_q     <= POS_MID;
      cnt_q     <= '0;
      lfsr_q    <= 8'h01;
      clear_q   <= 1'b1;
      fs_q      <= 1'b0;
      rd_q      <= 1'b0;
      push_m_q  <= 1'b0;
      push_s_q  <= 1'b0;
      tie_m_q   <= 1'b0;
      tie_s_q   <= 1'b0;
      right_m_q <= 1'b0;
      right_s_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      clear_q   <= clear_d;
      fs_q      <= fs_d;
      rd_q      <= rd_d;
      push_m_q  <= push;
      push_s_q  <= push_m_q;
      tie_m_q   <= tie;
      tie_s_q   <= tie_m_q;
      right_m_q <= right;
      right_s_q <= right_m_q;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    fs_d    = fs_q;
    rd_d    = 1'b0;
    step_up = 1'b0;
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    unique case (state_q)
      S_IDLE: if (start) state_d = S_ARM;
      S_ARM: begin
        cnt_d   = CNT_W'(MIN_DELAY) + CNT_W'(lfsr_q);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (push_s_q) begin
          fs_d    = 1'b1;
          state_d = S_SCORE;
        end else if (cnt_q == '0) begin
          state_d = S_GO;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GO: if (push_s_q) state_d = S_SCORE;
      S_SCORE: begin
        rd_d    = 1'b1;
        // A false start hands the step to the player who did not jump.
        step_up = right_s_q ^ fs_q;
        if (!tie_s_q) begin
          if (step_up) pos_d = (pos_q == POS_TOP) ? POS_TOP : pos_q + POS_W'(1);
          else         pos_d = (pos_q == '0) ? '0 : pos_q - POS_W'(1);
        end
        if (pos_d == '0 || pos_d == POS_TOP) begin
          state_d = S_WIN;
        end else begin
          cnt_d   = CNT_W'(HOLD_TICKS);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          fs_d    = 1'b0;
          state_d = S_ARM;
        end else if (tick) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_WIN: begin
        if (start) begin
          pos_d   = POS_MID;
          fs_d    = 1'b0;
          state_d = S_ARM;
        end
      end
      default: state_d = S_IDLE;
    endcase

    clear_d = (state_q == S_IDLE) || (state_q == S_ARM) ||
              (state_q == S_HOLD) || (state_q == S_WIN);
  end

  assign clear        = clear_q;
  assign go           = (state_q == S_GO);
  assign pos          = pos_q;
  assign false_start  = fs_q;
  assign round_done   = rd_q;
  assign winner_valid = (state_q == S_WIN);
  assign winner_right = (state_q == S_WIN) && (pos_q == POS_TOP);

endmodule

// File: tb/tb_tow_round_ctrl.sv
// Bench for tow_round_ctrl: scripted and randomized rounds checked against a
// rope-position / timing model derived from the round rules.
module tb_tow_round_ctrl;

  localparam int unsigned POS_MAX    = 4;
  localparam int unsigned POS_W      = 4;
  localparam int unsigned MIN_DELAY  = 50;
  localparam int unsigned HOLD_TICKS = 500;
  localparam int unsigned CNT_W      = 10;
  localparam int          TOP        = 2 * POS_MAX;

  logic clk = 1'b0;
  logic rst, tick, start, push, tie, right;
  logic clear, go, false_start, round_done, winner_valid, winner_right;
  logic [POS_W-1:0] pos;

  int n_checks = 0;
  int n_err    = 0;
  int exp_pos;
  int exp_n;
  bit won;
  logic [7:0] m_lfsr, lf_h1, lf_h2;

  tow_round_ctrl #(
    .POS_MAX(POS_MAX), .POS_W(POS_W), .MIN_DELAY(MIN_DELAY),
    .HOLD_TICKS(HOLD_TICKS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .push(push), .tie(tie),
    .right(right), .clear(clear), .go(go), .pos(pos), .false_start(false_start),
    .round_done(round_done), .winner_valid(winner_valid), .winner_right(winner_right)
  );

  always #5 clk = ~clk;

  // Reference random sequence: taps 8,6,5,4 (1-based), shifting towards the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always @(posedge clk) begin
    lf_h2  <= lf_h1;
    lf_h1  <= m_lfsr;
    m_lfsr <= rst ? 8'h01 : lfsr_step(m_lfsr);
  end

  // kind: 0 = left only, 1 = right only, 2 = tie
  function automatic int next_pos(input int p, input bit early, input int kind);
    int  p2;
    bit  right_scores;
    p2 = p;
    if (kind != 2) begin
      right_scores = (kind == 1) != early;
      p2 = right_scores ? p + 1 : p - 1;
      if (p2 < 0) p2 = 0;
      if (p2 > TOP) p2 = TOP;
    end
    return p2;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_clear_fall(input string tag);
    int k;
    k = 0;
    while (clear !== 1'b0 && k < 1200) begin @(negedge clk); k++; end
    n_checks++;
    if (clear !== 1'b0) begin n_err++; $display("FAIL %s_arm_timeout: clear=%b want 0", tag, clear); end
    exp_n = int'(MIN_DELAY) + int'(lf_h2);
  endtask

  task automatic wait_rearm(input string tag, input int want_k);
    int k;
    k = 0;
    while (clear !== 1'b0 && k < int'(HOLD_TICKS) + 20) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== want_k) begin n_err++; $display("FAIL %s_hold_len: got %0d cycles want %0d", tag, k, want_k); end
    n_checks++;
    if (false_start !== 1'b0) begin n_err++; $display("FAIL %s_fs_cleared: got %b want 0", tag, false_start); end
    exp_n = int'(MIN_DELAY) + int'(lf_h2);
  endtask

  task automatic wait_go(input string tag);
    int k;
    k = 0;
    while (go !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    n_checks++;
    if (k !== exp_n) begin n_err++; $display("FAIL %s_go_delay: got %0d cycles want %0d", tag, k, exp_n); end
    n_checks++;
    if (clear !== 1'b0) begin n_err++; $display("FAIL %s_clear_in_go: got %b want 0", tag, clear); end
  endtask

  task automatic push_round(input bit early, input int kind, input string tag, output bit w);
    int k;
    if (early) repeat ($urandom_range(0, 20)) @(negedge clk);
    else begin
      wait_go(tag);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    exp_pos = next_pos(exp_pos, early, kind);
    push  = 1'b1;
    tie   = (kind == 2);
    right = (kind == 1);
    k = 0;
    do begin @(negedge clk); k++; end while (round_done !== 1'b1 && k < 8);
    n_checks++;
    if (k !== 4) begin n_err++; $display("FAIL %s_latency: got %0d cycles want 4", tag, k); end
    n_checks++;
    if (int'(pos) !== exp_pos) begin n_err++; $display("FAIL %s_pos: got %0d want %0d", tag, pos, exp_pos); end
    n_checks++;
    if (false_start !== early) begin n_err++; $display("FAIL %s_fs: got %b want %b", tag, false_start, early); end
    n_checks++;
    if (go !== 1'b0) begin n_err++; $display("FAIL %s_go_after: got %b want 0", tag, go); end
    w = (exp_pos == 0) || (exp_pos == TOP);
    n_checks++;
    if (winner_valid !== w) begin n_err++; $display("FAIL %s_wv: got %b want %b", tag, winner_valid, w); end
    if (w) begin
      n_checks++;
      if (winner_right !== (exp_pos == TOP)) begin
        n_err++; $display("FAIL %s_wr: got %b want %b", tag, winner_right, exp_pos == TOP);
      end
    end
    @(negedge clk);
    n_checks++;
    if (round_done !== 1'b0) begin n_err++; $display("FAIL %s_rd_pulse: got %b want 0", tag, round_done); end
    n_checks++;
    if (clear !== 1'b1) begin n_err++; $display("FAIL %s_clear_hold: got %b want 1", tag, clear); end
    n_checks++;
    if (false_start !== early) begin n_err++; $display("FAIL %s_fs_hold: got %b want %b", tag, false_start, early); end
    push = 1'b0; tie = 1'b0; right = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b1; start = 1'b0; push = 1'b0; tie = 1'b0; right = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (clear !== 1'b1) begin n_err++; $display("FAIL reset_clear: got %b want 1", clear); end
    n_checks++; if (go !== 1'b0) begin n_err++; $display("FAIL reset_go: got %b want 0", go); end
    n_checks++; if (pos !== POS_W'(POS_MAX)) begin n_err++; $display("FAIL reset_pos: got %0d want %0d", pos, POS_MAX); end
    n_checks++; if (false_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b want 0", false_start); end
    n_checks++; if (round_done !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", round_done); end
    n_checks++; if (winner_valid !== 1'b0 || winner_right !== 1'b0) begin
      n_err++; $display("FAIL reset_winner: got %b%b want 00", winner_valid, winner_right);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (clear !== 1'b1) begin n_err++; $display("FAIL idle_clear: got %b want 1", clear); end
    exp_pos = POS_MAX;
  endtask

  task automatic test_first_round();
    pulse_start();
    n_checks++; if (clear !== 1'b1) begin n_err++; $display("FAIL start_clear1: got %b want 1", clear); end
    @(negedge clk);
    n_checks++; if (clear !== 1'b1) begin n_err++; $display("FAIL start_clear2: got %b want 1", clear); end
    @(negedge clk);
    n_checks++; if (clear !== 1'b0) begin n_err++; $display("FAIL start_clear_fall: got %b want 0", clear); end
    exp_n = int'(MIN_DELAY) + int'(lf_h2);
    push_round(1'b0, 1, "right_win", won);
    wait_rearm("right_win", int'(HOLD_TICKS) + 2);
  endtask

  task automatic test_tie();
    push_round(1'b0, 2, "tie", won);
    wait_rearm("tie", int'(HOLD_TICKS) + 2);
  endtask

  task automatic test_false_start();
    push_round(1'b1, 0, "false_start", won);
    wait_rearm("false_start", int'(HOLD_TICKS) + 2);
  endtask

  task automatic test_left_wins();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pos = POS_MAX;
    pulse_start();
    wait_clear_fall("left_wins");
    for (int i = 0; i < 4; i++) begin
      push_round(1'b0, 0, "left_wins", won);
      if (i < 3) begin
        pulse_start();
        wait_rearm("left_wins", int'(HOLD_TICKS) + 1);
      end
    end
    repeat (5) @(negedge clk);
    n_checks++; if (winner_valid !== 1'b1 || pos !== '0) begin
      n_err++; $display("FAIL win_hold: got wv=%b pos=%0d want wv=1 pos=0", winner_valid, pos);
    end
    pulse_start();
    n_checks++; if (pos !== POS_W'(POS_MAX)) begin n_err++; $display("FAIL win_restart_pos: got %0d want %0d", pos, POS_MAX); end
    n_checks++; if (winner_valid !== 1'b0) begin n_err++; $display("FAIL win_restart_wv: got %b want 0", winner_valid); end
    exp_pos = POS_MAX;
    wait_clear_fall("win_restart");
  endtask

  task automatic test_random_rounds();
    bit early;
    int kind;
    for (int r = 0; r < 10; r++) begin
      early = ($urandom_range(0, 3) == 0);
      kind  = int'($urandom_range(0, 2));
      push_round(early, kind, "random", won);
      if (won) begin
        pulse_start();
        exp_pos = POS_MAX;
        n_checks++; if (pos !== POS_W'(POS_MAX)) begin n_err++; $display("FAIL random_restart_pos: got %0d want %0d", pos, POS_MAX); end
        wait_clear_fall("random");
      end else begin
        wait_rearm("random", int'(HOLD_TICKS) + 2);
      end
    end
  endtask

  task automatic test_reset_mid_go();
    int hits;
    wait_go("rst_mid_go");
    push = 1'b1; right = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (go !== 1'b0) begin n_err++; $display("FAIL rst_go: got %b want 0", go); end
    n_checks++; if (clear !== 1'b1) begin n_err++; $display("FAIL rst_clear: got %b want 1", clear); end
    n_checks++; if (pos !== POS_W'(POS_MAX)) begin n_err++; $display("FAIL rst_pos: got %0d want %0d", pos, POS_MAX); end
    n_checks++; if (winner_valid !== 1'b0) begin n_err++; $display("FAIL rst_wv: got %b want 0", winner_valid); end
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (round_done !== 1'b0 || go !== 1'b0 || clear !== 1'b1) hits++;
    end
    n_checks++; if (hits !== 0) begin n_err++; $display("FAIL rst_idle_quiet: got %0d bad cycles want 0", hits); end
    push = 1'b0; right = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_tie();
    test_false_start();
    test_left_wins();
    test_random_rounds();
    test_reset_mid_go();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
